// File: rtl/heart_lives_overlay_if.sv
// Scan-side, sprite-ROM and composited-output signals of the heart lives overlay.
// The overlay block connects through the slave modport.
interface heart_lives_overlay_if;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        de;
   logic        frame_start;
   logic [2:0]  lives;
   logic        hit;
   logic [15:0] bg_rgb;
   logic [5:0]  rom_x;
   logic [5:0]  rom_y;
   logic [15:0] rom_rgb;
   logic [15:0] out_rgb;
   logic        out_de;

   modport master (
      output pix_x, pix_y, de, frame_start, lives, hit, bg_rgb, rom_rgb,
      input  rom_x, rom_y, out_rgb, out_de
   );

   modport slave (
      input  pix_x, pix_y, de, frame_start, lives, hit, bg_rgb, rom_rgb,
      output rom_x, rom_y, out_rgb, out_de
   );
endinterface

// File: rtl/heart_lives_overlay.sv
// Draws a row of heart sprites (one per remaining life) over the background video,
// addressing an external 1-cycle-latency sprite ROM and blinking the last heart after a hit.
module heart_lives_overlay #(
   parameter int X0           = 16,
   parameter int Y0           = 16,
   parameter int SPR_W        = 64,
   parameter int SPR_H        = 20,
   parameter int SPACING      = 72,
   parameter int MAX_LIVES    = 5,
   parameter int BLINK_FRAMES = 32,
   parameter int BLINK_HALF   = 4
) (
   input logic                   clk,
   input logic                   rst,
   heart_lives_overlay_if.slave  bus
);

   localparam int FRM_W  = $clog2(BLINK_FRAMES + 1);
   localparam int HALF_W = $clog2(BLINK_HALF + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BLINK = 1'b1
   } state_t;

   state_t            state_r;
   logic [FRM_W-1:0]  blink_frm_r;
   logic [HALF_W-1:0] half_cnt_r;
   logic              vis_r;
   logic [2:0]        lives_q_r;

   logic [9:0]        dx_s;
   logic [9:0]        dy_s;
   logic [2:0]        slot_s;
   logic [9:0]        off_s;
   logic              vis_ok_s;
   logic              in_spr_s;

   logic              spr_d_r;
   logic              de_d_r;
   logic [15:0]       bg_d_r;
   logic [15:0]       out_rgb_r;
   logic              out_de_r;

   function automatic logic [2:0] clamp_lives(input logic [2:0] req);
      logic [2:0] res;
      if (req > 3'(MAX_LIVES)) begin
         res = 3'(MAX_LIVES);
      end else begin
         res = req;
      end
      return res;
   endfunction

   // Stage 0: position inside the heart row and sprite hit test, from the live scan position.
   always_comb begin
      dx_s   = bus.pix_x - 10'(X0);
      dy_s   = bus.pix_y - 10'(Y0);
      slot_s = 3'd0;
      // Slot found by comparing against constant multiples of the pitch.
      for (int k = 1; k <= MAX_LIVES; k++) begin
         if ({6'd0, dx_s} >= 16'(k * SPACING)) begin
            slot_s = 3'(k);
         end else begin
            slot_s = slot_s;
         end
      end
      off_s    = dx_s - 10'(int'(slot_s) * SPACING);
      vis_ok_s = !((state_r == BLINK) && !vis_r && (slot_s == (lives_q_r - 3'd1)));
      in_spr_s = bus.de
               && (bus.pix_x >= 10'(X0))
               && (bus.pix_y >= 10'(Y0))
               && (dy_s < 10'(SPR_H))
               && (slot_s < lives_q_r)
               && (off_s < 10'(SPR_W))
               && vis_ok_s;
      if (in_spr_s) begin
         bus.rom_x = off_s[5:0];
         bus.rom_y = dy_s[5:0];
      end else begin
         bus.rom_x = 6'd0;
         bus.rom_y = 6'd0;
      end
   end

   // Per-frame lives latch and blink state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         blink_frm_r <= '0;
         half_cnt_r  <= '0;
         vis_r       <= 1'b1;
         lives_q_r   <= 3'd0;
      end else begin
         if (bus.frame_start) begin
            lives_q_r <= clamp_lives(bus.lives);
         end else begin
            lives_q_r <= lives_q_r;
         end
         case (state_r)
            IDLE: begin
               if (bus.hit) begin
                  state_r     <= BLINK;
                  blink_frm_r <= '0;
                  half_cnt_r  <= '0;
                  vis_r       <= 1'b0;
               end else begin
                  vis_r       <= 1'b1;
               end
            end
            BLINK: begin
               // A hit restarts the blink and suppresses the frame count for that cycle.
               if (bus.hit) begin
                  blink_frm_r <= '0;
                  half_cnt_r  <= '0;
                  vis_r       <= 1'b0;
               end else if (bus.frame_start) begin
                  if (blink_frm_r == FRM_W'(BLINK_FRAMES - 1)) begin
                     state_r     <= IDLE;
                     blink_frm_r <= '0;
                     half_cnt_r  <= '0;
                     vis_r       <= 1'b1;
                  end else begin
                     blink_frm_r <= blink_frm_r + FRM_W'(1);
                     if (half_cnt_r == HALF_W'(BLINK_HALF - 1)) begin
                        half_cnt_r <= '0;
                        vis_r      <= ~vis_r;
                     end else begin
                        half_cnt_r <= half_cnt_r + HALF_W'(1);
                     end
                  end
               end else begin
                  blink_frm_r <= blink_frm_r;
               end
            end
            default: begin
               state_r     <= IDLE;
               blink_frm_r <= '0;
               half_cnt_r  <= '0;
               vis_r       <= 1'b1;
            end
         endcase
      end
   end

   // Stage 1: hold pixel attributes while the ROM fetches the sprite pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         spr_d_r <= 1'b0;
         de_d_r  <= 1'b0;
         bg_d_r  <= 16'd0;
      end else begin
         spr_d_r <= in_spr_s;
         de_d_r  <= bus.de;
         bg_d_r  <= bus.bg_rgb;
      end
   end

   // Stage 2: composite the sprite over the background, black outside active video.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_rgb_r <= 16'd0;
         out_de_r  <= 1'b0;
      end else begin
         out_de_r <= de_d_r;
         if (!de_d_r) begin
            out_rgb_r <= 16'd0;
         end else if (spr_d_r && (bus.rom_rgb != 16'd0)) begin
            out_rgb_r <= bus.rom_rgb;
         end else begin
            out_rgb_r <= bg_d_r;
         end
      end
   end

   assign bus.out_rgb = out_rgb_r;
   assign bus.out_de  = out_de_r;

endmodule

// File: tb/tb_heart_lives_overlay.sv
// Bench for heart_lives_overlay: table vectors plus frame/blink/reset sequences,
// expected outputs queued at drive time and compared two clocks later.
module tb_heart_lives_overlay;
   localparam int X0 = 16, Y0 = 16, SPR_W = 64, SPR_H = 20, SPACING = 72;
   localparam int MAX_LIVES = 5, BLINK_FRAMES = 32, BLINK_HALF = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   heart_lives_overlay_if bus();

   heart_lives_overlay #(
      .X0(X0), .Y0(Y0), .SPR_W(SPR_W), .SPR_H(SPR_H), .SPACING(SPACING),
      .MAX_LIVES(MAX_LIVES), .BLINK_FRAMES(BLINK_FRAMES), .BLINK_HALF(BLINK_HALF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Sprite ROM stand-in: column 7 is transparent, (0,0) is red.
   function automatic logic [15:0] rom_f(input logic [5:0] x, input logic [5:0] y);
      if (x == 6'd7) return 16'h0000;
      else if (x == 6'd0 && y == 6'd0) return 16'hF800;
      else return {y[4:0], x, 5'h15};
   endfunction

   always @(posedge clk) bus.rom_rgb <= rom_f(bus.rom_x, bus.rom_y);

   typedef struct {
      logic [9:0]  x, y;
      logic        de;
      logic [15:0] bg;
      logic        fs, hit;
      logic [2:0]  lives;
      logic        rst;
      logic [5:0]  exp_rx, exp_ry;
      logic [15:0] exp_rgb;
      logic        exp_de;
   } vec_t;

   typedef struct packed {
      logic [15:0] rgb;
      logic        de;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   m_lives = 0;
   bit   m_blink = 1'b0;
   int   m_fsh = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
      end
   endtask

   function automatic vec_t mk(input int x, input int y, input bit de, input logic [15:0] bg,
                               input int rx, input int ry, input logic [15:0] rgb);
      vec_t v;
      v.x = 10'(x); v.y = 10'(y); v.de = de; v.bg = bg;
      v.fs = 1'b0; v.hit = 1'b0; v.lives = 3'd3; v.rst = 1'b0;
      v.exp_rx = 6'(rx); v.exp_ry = 6'(ry); v.exp_rgb = rgb; v.exp_de = de;
      return v;
   endfunction

   // Reference geometry using true division, with blink phase from frames since the hit.
   function automatic vec_t model_fill(input vec_t v);
      vec_t r = v;
      int dx, dy, slot, off;
      bit in_s, hidden;
      dx = int'(v.x) - X0;
      dy = int'(v.y) - Y0;
      in_s = v.de && dx >= 0 && dy >= 0 && dy < SPR_H;
      slot = in_s ? dx / SPACING : 0;
      off  = in_s ? dx % SPACING : 0;
      hidden = m_blink && (((m_fsh / BLINK_HALF) % 2) == 0);
      in_s = in_s && slot < m_lives && off < SPR_W && !(hidden && slot == m_lives - 1);
      r.exp_rx = in_s ? 6'(off) : 6'd0;
      r.exp_ry = in_s ? 6'(dy) : 6'd0;
      r.exp_de = v.de;
      if (!v.de) r.exp_rgb = 16'd0;
      else if (in_s && rom_f(r.exp_rx, r.exp_ry) != 16'd0) r.exp_rgb = rom_f(r.exp_rx, r.exp_ry);
      else r.exp_rgb = v.bg;
      return r;
   endfunction

   task automatic step(input vec_t v);
      exp_t e;
      bus.pix_x = v.x; bus.pix_y = v.y; bus.de = v.de; bus.bg_rgb = v.bg;
      bus.frame_start = v.fs; bus.hit = v.hit; bus.lives = v.lives; rst = v.rst;
      #1;
      if (v.rst) begin
         exp_q.delete();
         exp_q.push_back('0);
         exp_q.push_back('0);
         m_lives = 0; m_blink = 1'b0; m_fsh = 0;
      end else begin
         check("rom_x", 32'(bus.rom_x), 32'(v.exp_rx));
         check("rom_y", 32'(bus.rom_y), 32'(v.exp_ry));
         exp_q.push_back({v.exp_rgb, v.exp_de});
         if (v.hit) begin
            m_blink = 1'b1; m_fsh = 0;
         end else if (v.fs && m_blink) begin
            m_fsh++;
            if (m_fsh == BLINK_FRAMES) m_blink = 1'b0;
         end
         if (v.fs) m_lives = (int'(v.lives) > MAX_LIVES) ? MAX_LIVES : int'(v.lives);
      end
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("out_rgb", 32'(bus.out_rgb), 32'(e.rgb));
         check("out_de", 32'(bus.out_de), 32'(e.de));
      end
   endtask

   task automatic mstep(input int x, input int y, input bit de, input logic [15:0] bg,
                        input bit fs, input bit hit, input int lives, input bit r);
      vec_t v;
      v = mk(x, y, de, bg, 0, 0, 16'd0);
      v.fs = fs; v.hit = hit; v.lives = 3'(lives); v.rst = r;
      step(model_fill(v));
   endtask

   task automatic heart_pixels(input logic [15:0] bg);
      for (int k = 0; k < 3; k++) mstep(X0 + k * SPACING + 5, Y0 + 4, 1'b1, bg, 1'b0, 1'b0, 3, 1'b0);
   endtask

   vec_t tbl[15];

   initial begin
      tbl[0]  = mk(16, 16, 1'b1, 16'h1234, 0, 0, 16'hF800);
      tbl[1]  = mk(93, 20, 1'b1, 16'h1234, 5, 4, 16'h20B5);
      tbl[2]  = mk(232, 16, 1'b1, 16'h1234, 0, 0, 16'h1234);
      tbl[3]  = mk(80, 16, 1'b1, 16'h2345, 0, 0, 16'h2345);
      tbl[4]  = mk(87, 16, 1'b1, 16'h3456, 0, 0, 16'h3456);
      tbl[5]  = mk(15, 16, 1'b1, 16'h4567, 0, 0, 16'h4567);
      tbl[6]  = mk(16, 36, 1'b1, 16'h5678, 0, 0, 16'h5678);
      tbl[7]  = mk(16, 35, 1'b1, 16'h5678, 0, 19, 16'h9815);
      tbl[8]  = mk(23, 17, 1'b1, 16'h07E0, 7, 1, 16'h07E0);
      tbl[9]  = mk(16, 16, 1'b0, 16'hFFFF, 0, 0, 16'h0000);
      tbl[10] = mk(88, 16, 1'b1, 16'h0101, 0, 0, 16'hF800);
      tbl[11] = mk(231, 16, 1'b1, 16'h0202, 0, 0, 16'h0202);
      tbl[12] = mk(223, 16, 1'b1, 16'h0303, 63, 0, 16'h07F5);
      tbl[13] = mk(160, 25, 1'b1, 16'h0404, 0, 9, 16'h4815);
      tbl[14] = mk(100, 15, 1'b1, 16'h0505, 0, 0, 16'h0505);

      // Reset, then nothing drawn until lives are latched.
      for (int i = 0; i < 3; i++) mstep(16, 16, 1'b1, 16'hAAAA, 1'b0, 1'b1, 3, 1'b1);
      mstep(16, 16, 1'b1, 16'h0BAD, 1'b0, 1'b0, 3, 1'b0);
      mstep(0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b0);

      for (int i = 0; i < 15; i++) step(tbl[i]);
      for (int i = 0; i < 2; i++) mstep(0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 3, 1'b0);

      // Lives change mid-frame only applies at the next frame start; request above max is clamped.
      mstep(160, 25, 1'b1, 16'h0123, 1'b0, 1'b0, 1, 1'b0);
      mstep(0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
      mstep(160, 25, 1'b1, 16'h0123, 1'b0, 1'b0, 1, 1'b0);
      mstep(16, 16, 1'b1, 16'h0123, 1'b0, 1'b0, 1, 1'b0);
      mstep(0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 7, 1'b0);
      mstep(304, 16, 1'b1, 16'h0456, 1'b0, 1'b0, 7, 1'b0);
      mstep(376, 16, 1'b1, 16'h0456, 1'b0, 1'b0, 7, 1'b0);
      mstep(0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
      mstep(16, 16, 1'b1, 16'h0789, 1'b0, 1'b0, 0, 1'b0);

      // Blink: hit together with frame start at frame 0, restart hit at frame 10.
      mstep(0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b0);
      for (int f = 0; f < 46; f++) begin
         mstep(0, 0, 1'b0, 16'h0000, 1'b1, (f == 0 || f == 10), 3, 1'b0);
         heart_pixels(16'h0F0F);
      end

      // Mid-frame hit, a few frames, then reset aborts the blink.
      mstep(0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b0);
      mstep(0, 0, 1'b0, 16'h0000, 1'b0, 1'b1, 3, 1'b0);
      for (int f = 0; f < 5; f++) begin
         mstep(0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b0);
         heart_pixels(16'h3C3C);
      end
      mstep(160, 20, 1'b1, 16'h3C3C, 1'b0, 1'b0, 3, 1'b1);
      mstep(160, 20, 1'b1, 16'h5A5A, 1'b0, 1'b0, 3, 1'b0);
      mstep(0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b0);
      heart_pixels(16'h5A5A);
      for (int i = 0; i < 2; i++) mstep(0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/heart_lives_overlay.md
Name: heart_lives_overlay

Overview:
- Upstream/downstream companion of the 64x20 heart sprite ROM (6-bit x/y address in, registered RGB565 out, 1-cycle latency).
- Takes the display scan position and background pixel, draws a row of up to MAX_LIVES hearts (one per remaining life), and addresses the ROM.
- Composites ROM pixels over the background with 0x0000 treated as transparent.
- Blinks the last heart for a fixed number of frames after a hit; sits between the scan timing generator and the display output register.

Parameters:
- X0, 16, screen x of left edge of heart 0
- Y0, 16, screen y of top row of all hearts
- SPR_W, 64, sprite width in pixels (≤64)
- SPR_H, 20, sprite height in lines (≤64)
- SPACING, 72, x pitch between heart origins (≥SPR_W)
- MAX_LIVES, 5, maximum hearts drawn
- BLINK_FRAMES, 32, frames of blinking after a hit
- BLINK_HALF, 4, frames per on/off half-period

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_x  in  10  current scan column
- pix_y  in  10  current scan line
- de  in  1  active-video qualifier for pix_x/pix_y/bg_rgb
- frame_start  in  1  one-cycle pulse at start of frame (before first active line)
- lives  in  3  requested heart count
- hit  in  1  one-cycle pulse: player hit, start blink
- bg_rgb  in  16  background RGB565 for current pixel
- rom_x  out  6  sprite column to ROM (combinational)
- rom_y  out  6  sprite row to ROM (combinational)
- rom_rgb  in  16  ROM data, valid one cycle after rom_x/rom_y
- out_rgb  out  16  composited pixel, registered
- out_de  out  1  de delayed to match out_rgb

Behaviour:
- Reset: out_rgb=0, out_de=0, lives_q=0, state=IDLE, blink_frm=0, vis=1; all pipeline regs cleared. Reset mid-blink aborts blink immediately.
- Lives latch: on frame_start, lives_q <= min(lives, MAX_LIVES). Changes of lives mid-frame take effect only at the next frame_start (no tearing).
- Hit test (stage 0, combinational on pix_*): dx=pix_x-X0, dy=pix_y-Y0; slot=dx div SPACING, off=dx mod SPACING.
- in_spr = de & pix_x≥X0 & pix_y≥Y0 & dy<SPR_H & slot<lives_q & off<SPR_W & vis_ok.
- vis_ok = 1 unless state=BLINK, vis=0 and slot==lives_q-1; only the last heart blinks.
- slot/off via incremental per-line counters (reset when pix_x==X0) or constant-divisor logic; no generic divider.
- rom_x=off[5:0], rom_y=dy[5:0] when in_spr, else both 0.
- Stage 1: register in_spr→spr_d, de→de_d, bg_rgb→bg_d, aligned with rom_rgb.
- Stage 2: out_rgb <= !de_d ? 0 : (spr_d & rom_rgb!=0) ? rom_rgb : bg_d; out_de <= de_d.
- Total latency pix_*/bg_rgb → out_rgb/out_de = 2 cycles, fully pipelined, one pixel per clk.
- Blink FSM, IDLE:
  - hit → BLINK, blink_frm=0, vis=0.
- Blink FSM, BLINK, on each frame_start:
  - blink_frm++.
  - Toggle vis when blink_frm+1 is a multiple of BLINK_HALF.
  - When blink_frm+1==BLINK_FRAMES → IDLE, vis=1.
- hit while in BLINK restarts: blink_frm=0, vis=0.
- hit and frame_start in the same cycle: hit wins; the restart applies, with no increment.
- vis changes only at frame_start or hit, never mid-line after the first frame_start of the blink.
- lives_q==0: no hearts drawn, output = background; blink FSM still runs.
- Heart region exceeding the screen: no wrap, columns beyond the scan are simply never reached.
- Gap columns (off in SPR_W..SPACING-1) → background.

Test Plan:
- Address and latency: lives=3 latched, scan (16,16) de=1 → rom_x=0, rom_y=0 same cycle; ROM returns 0xF800 → out_rgb=0xF800 exactly 2 clks later; (93,20) → rom_x=5, rom_y=4.
- Slot and gap limits: lives=3, x=232 (slot 3) → rom_x=0, out_rgb=bg_rgb; x=80..87 (gap) → bg; x=15 or y=36 → bg.
- Transparency and de: rom_rgb=0x0000 inside sprite with bg=0x07E0 → out_rgb=0x07E0; de=0 with any inputs → out_rgb=0, out_de=0 two clks later.
- Lives latch and clamp: lives 3→1 mid-frame → still 3 hearts until next frame_start, then 1; lives=7 → 5 hearts drawn.
- Blink: lives=3, hit → heart 2 hidden frames 0-3, shown 4-7, …; hearts 0-1 always shown; after 32 frames steady on. Second hit at frame 10 restarts the count.
- Reset mid-blink: rst at frame 5 → next cycle out_rgb=0, out_de=0, state IDLE; after lives relatched, all hearts visible.
